riscv_prog_harness: RTL and testbench
=====================================

// Module: riscv_prog_harness
// PURPOSE
//  Synthesisable run-and-check harness for the RISC-V pipelined core.
//  Streams a program into instruction memory, runs the core until HLT or a timeout,
//  drains the pipeline, then reads back selected registers and compares them against an expected table.
//  Replaces hand-written per-program initial blocks; one harness instance serves any program and any check set.
// PARAMETERS
//  XLEN        32    data/instruction width
//  IMEM_AW     6     instruction memory address width; depth = 2**IMEM_AW
//  NUM_CHECKS  8     entries in the expected-value table
//  TIMEOUT     200   max RUN cycles before abort
//  DRAIN       4     cycles waited after core_halted before readback
// PORTS
//  clk1          in   1            single clock, rising edge
//  rst           in   1            synchronous, active-high reset
//  start         in   1            pulse; honoured only in IDLE or DONE
//  ld_valid      in   1            program word valid
//  ld_ready      out  1            harness accepts program word
//  ld_data       in   XLEN         program word, loaded at ascending addresses from 0
//  ld_last       in   1            marks final program word
//  chk_we        in   1            expected-table write; honoured only in IDLE or DONE
//  chk_idx       in   clog2(NUM_CHECKS)  table entry index
//  chk_en        in   1            entry enable
//  chk_reg       in   5            register number to check
//  chk_val       in   XLEN         expected value
//  imem_we       out  1            instruction memory write strobe
//  imem_addr     out  IMEM_AW      instruction memory write address
//  imem_wdata    out  XLEN         instruction memory write data
//  core_run      out  1            enables core clocking/PC advance
//  core_halted   in   1            core HALTED flag
//  reg_rd_addr   out  5            register-file debug read address
//  reg_rd_data   in   XLEN         register data, valid 1 cycle after address
//  done          out  1            result valid; held until start or rst
//  pass          out  1            all enabled checks matched
//  timeout       out  1            RUN exceeded TIMEOUT
//  overflow      out  1            program longer than IMEM depth
//  fail_idx      out  clog2(NUM_CHECKS)  first failing entry
//  cycle_count   out  16           RUN cycles until halt (saturating)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; all chk_en cleared; load pointer 0.
//  States: IDLE -> LOAD -> RUN -> DRAIN -> CHECK -> DONE; DONE -start-> LOAD.
//  start in IDLE/DONE: clear done/pass/timeout/overflow/fail_idx/cycle_count and the load pointer; enter LOAD.
//  start in any other state is ignored.
//  LOAD: ld_ready=1. A transfer occurs when ld_valid && ld_ready.
//  On a transfer, the next cycle asserts imem_we=1, imem_addr=ptr, imem_wdata=ld_data; ptr increments.
//  A transfer with ld_last, or a transfer at ptr==DEPTH-1, enters RUN after its write.
//  If the word at DEPTH-1 is not flagged ld_last: overflow=1, go to DONE with pass=0. The core is never run.
//  RUN: core_run=1; cycle_count increments each cycle and saturates at 16'hFFFF.
//  On core_halted=1, go to DRAIN.
//  If TIMEOUT cycles elapse without halt: timeout=1, pass=0, core_run=0, go to DONE.
//  Halt and the final timeout cycle in the same cycle: halt wins.
//  DRAIN: core_run stays 1 for DRAIN cycles so the MEM/WB instructions behind HLT retire; then core_run=0.
//  CHECK: entries are scanned in index order 0..NUM_CHECKS-1, 2 cycles per entry (addr, compare).
//  Disabled entries take the same 2 cycles and never fail.
//  On the first mismatch: fail_idx=index, pass=0, go to DONE; the scan stops.
//  If no entry mismatches: pass=1. With all entries disabled, pass=1.
//  DONE: done=1; outputs are stable; ld_ready=0; core_run=0.
//  Comparison is a full XLEN-bit equality. reg_rd_addr=0 compares against 0.
//  rst in any state, including mid-RUN, returns to the reset state within 1 cycle. The expected table is cleared.
//  chk_we is ignored outside IDLE/DONE, so the table cannot change during a run.
// TESTING
//  Load {480200d2,1c410000,00222000,04822800,fc000000} with ld_last on word 4.
//    Core model halts after 12 RUN cycles. Checks R1=40, R2=210, R4=250, R5=40.
//    Expect done=1, pass=1, cycle_count=12.
//  Same program, with check 2 expecting R4=251 -> pass=0, fail_idx=2. Check 3 is never read.
//  Core model never asserts halted -> after 200 RUN cycles, timeout=1, pass=0, done=1.
//  Stream 65 words with no ld_last (IMEM_AW=6) -> overflow=1 after word 63.
//    ld_ready=0 thereafter; core_run never asserted.
//  Pulse start mid-RUN -> ignored. Assert rst at RUN cycle 5 -> all outputs 0 next cycle; chk_en cleared.
//  ld_valid toggled randomly in LOAD -> exactly one imem write per transfer, at consecutive addresses, with no gaps or duplicates.

Source files
------------

// File: rtl/riscv_prog_harness.sv
`timescale 1ns/1ps
// Run-and-check harness: streams a program into IMEM, runs the core until HLT or timeout,
// drains the pipeline, then compares selected registers against an expected-value table.
module riscv_prog_harness #(
  parameter int XLEN       = 32,
  parameter int IMEM_AW    = 6,
  parameter int NUM_CHECKS = 8,
  parameter int TIMEOUT    = 200,
  parameter int DRAIN      = 4,
  localparam int CIW       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                clk1_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                ld_valid_i,
  output logic                ld_ready_o,
  input  logic [XLEN-1:0]     ld_data_i,
  input  logic                ld_last_i,
  input  logic                chk_we_i,
  input  logic [CIW-1:0]      chk_idx_i,
  input  logic                chk_en_i,
  input  logic [4:0]          chk_reg_i,
  input  logic [XLEN-1:0]     chk_val_i,
  output logic                imem_we_o,
  output logic [IMEM_AW-1:0]  imem_addr_o,
  output logic [XLEN-1:0]     imem_wdata_o,
  output logic                core_run_o,
  input  logic                core_halted_i,
  output logic [4:0]          reg_rd_addr_o,
  input  logic [XLEN-1:0]     reg_rd_data_i,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic                overflow_o,
  output logic [CIW-1:0]      fail_idx_o,
  output logic [15:0]         cycle_count_o
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [IMEM_AW-1:0] LAST_ADDR  = '1;
  localparam logic [15:0]        TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [DCW-1:0]     DRAIN_LAST = DCW'(DRAIN - 1);
  localparam logic [CIW-1:0]     LAST_CHK   = CIW'(NUM_CHECKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t              state_q;
  logic [IMEM_AW-1:0]  loadPtr_q;
  logic                loadEnd_q;
  logic                loadOvf_q;
  logic [DCW-1:0]      drainCnt_q;
  logic [CIW-1:0]      chkPos_q;
  logic                chkPhase_q;
  logic                ldReady_q;
  logic                imemWe_q;
  logic [IMEM_AW-1:0]  imemAddr_q;
  logic [XLEN-1:0]     imemWdata_q;
  logic                coreRun_q;
  logic [4:0]          regRdAddr_q;
  logic                done_q;
  logic                pass_q;
  logic                timeout_q;
  logic                overflow_q;
  logic [CIW-1:0]      failIdx_q;
  logic [15:0]         cycleCount_q;

  logic                chkEn_q  [NUM_CHECKS];
  logic [4:0]          chkReg_q [NUM_CHECKS];
  logic [XLEN-1:0]     chkVal_q [NUM_CHECKS];

  logic                idleOrDone;
  logic                transfer;
  logic [XLEN-1:0]     rdData;
  logic                entryFail;

  assign idleOrDone = (state_q == S_IDLE) || (state_q == S_DONE);
  assign transfer   = ld_valid_i && ldReady_q;
  // x0 is hardwired to zero, whatever the debug port returns
  assign rdData     = (regRdAddr_q == 5'd0) ? '0 : reg_rd_data_i;
  assign entryFail  = chkEn_q[chkPos_q] && (rdData != chkVal_q[chkPos_q]);

  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CHECKS; i++) chkEn_q[i] <= 1'b0;
    end else if (chk_we_i && idleOrDone) begin
      chkEn_q[chk_idx_i]  <= chk_en_i;
      chkReg_q[chk_idx_i] <= chk_reg_i;
      chkVal_q[chk_idx_i] <= chk_val_i;
    end
  end

  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      loadPtr_q    <= '0;
      loadEnd_q    <= 1'b0;
      loadOvf_q    <= 1'b0;
      drainCnt_q   <= '0;
      chkPos_q     <= '0;
      chkPhase_q   <= 1'b0;
      ldReady_q    <= 1'b0;
      imemWe_q     <= 1'b0;
      imemAddr_q   <= '0;
      imemWdata_q  <= '0;
      coreRun_q    <= 1'b0;
      regRdAddr_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      failIdx_q    <= '0;
      cycleCount_q <= '0;
    end else begin
      imemWe_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            failIdx_q    <= '0;
            cycleCount_q <= '0;
            loadPtr_q    <= '0;
            loadEnd_q    <= 1'b0;
            loadOvf_q    <= 1'b0;
            ldReady_q    <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // loadEnd_q marks the cycle the final word is being written
          if (loadEnd_q) begin
            loadEnd_q <= 1'b0;
            if (loadOvf_q) begin
              overflow_q <= 1'b1;
              pass_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              coreRun_q <= 1'b1;
              state_q   <= S_RUN;
            end
          end else if (transfer) begin
            imemWe_q    <= 1'b1;
            imemAddr_q  <= loadPtr_q;
            imemWdata_q <= ld_data_i;
            loadPtr_q   <= loadPtr_q + 1'b1;
            if (ld_last_i || (loadPtr_q == LAST_ADDR)) begin
              ldReady_q <= 1'b0;
              loadEnd_q <= 1'b1;
              loadOvf_q <= !ld_last_i;
            end
          end
        end
        S_RUN: begin
          if (core_halted_i) begin
            drainCnt_q <= '0;
            state_q    <= S_DRAIN;
          end else begin
            if (cycleCount_q != 16'hFFFF) cycleCount_q <= cycleCount_q + 16'd1;
            if (cycleCount_q == TO_LAST) begin
              timeout_q <= 1'b1;
              pass_q    <= 1'b0;
              coreRun_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_DRAIN: begin
          if (drainCnt_q == DRAIN_LAST) begin
            coreRun_q   <= 1'b0;
            chkPos_q    <= '0;
            chkPhase_q  <= 1'b0;
            regRdAddr_q <= chkReg_q[0];
            state_q     <= S_CHECK;
          end else begin
            drainCnt_q <= drainCnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          // phase 0 presents the address, phase 1 compares the returned data
          if (!chkPhase_q) begin
            chkPhase_q <= 1'b1;
          end else if (entryFail) begin
            failIdx_q <= chkPos_q;
            pass_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (chkPos_q == LAST_CHK) begin
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            chkPos_q    <= chkPos_q + 1'b1;
            chkPhase_q  <= 1'b0;
            regRdAddr_q <= chkReg_q[chkPos_q + 1'b1];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ld_ready_o    = ldReady_q;
  assign imem_we_o     = imemWe_q;
  assign imem_addr_o   = imemAddr_q;
  assign imem_wdata_o  = imemWdata_q;
  assign core_run_o    = coreRun_q;
  assign reg_rd_addr_o = regRdAddr_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign overflow_o    = overflow_q;
  assign fail_idx_o    = failIdx_q;
  assign cycle_count_o = cycleCount_q;

endmodule

// File: tb/tb_riscv_prog_harness.sv
`timescale 1ns/1ps
// Directed bench for riscv_prog_harness with a small core model (halt after N run cycles)
// and a register-file model answering debug reads one cycle after the address.
module tb_riscv_prog_harness;

  localparam int XLEN = 32;
  localparam int IMEM_AW = 6;
  localparam int CIW = 3;

  logic               clk1 = 1'b0;
  logic               rst, start, ldValid, ldLast, chkWe, chkEn;
  logic               ldReady, imemWe, coreRun, coreHalted;
  logic [XLEN-1:0]    ldData, chkVal, imemWdata, regRdData;
  logic [CIW-1:0]     chkIdx, failIdx;
  logic [4:0]         chkReg, regRdAddr;
  logic [IMEM_AW-1:0] imemAddr;
  logic               done, pass, timeout, overflow;
  logic [15:0]        cycleCount;

  int testsRun = 0;
  int testsFailed = 0;

  logic [XLEN-1:0]    progMem [65];
  logic [XLEN-1:0]    regs [32];
  logic [IMEM_AW-1:0] imemAddrLog [128];
  logic [XLEN-1:0]    imemDataLog [128];
  int                 imemCount;
  int                 runEdges;
  logic               coreRunSeen, rdAddr5Seen;
  logic               haltEn = 1'b0;
  int                 haltAfter = 12;
  int                 accepted;

  riscv_prog_harness dut (
    .clk1_i(clk1), .rst_i(rst), .start_i(start),
    .ld_valid_i(ldValid), .ld_ready_o(ldReady), .ld_data_i(ldData), .ld_last_i(ldLast),
    .chk_we_i(chkWe), .chk_idx_i(chkIdx), .chk_en_i(chkEn), .chk_reg_i(chkReg), .chk_val_i(chkVal),
    .imem_we_o(imemWe), .imem_addr_o(imemAddr), .imem_wdata_o(imemWdata),
    .core_run_o(coreRun), .core_halted_i(coreHalted),
    .reg_rd_addr_o(regRdAddr), .reg_rd_data_i(regRdData),
    .done_o(done), .pass_o(pass), .timeout_o(timeout), .overflow_o(overflow),
    .fail_idx_o(failIdx), .cycle_count_o(cycleCount)
  );

  always #5 clk1 = ~clk1;

  assign coreHalted = haltEn && (runEdges >= haltAfter);

  always @(posedge clk1) regRdData <= (regRdAddr == 5'd0) ? '0 : regs[regRdAddr];

  // Observers: IMEM write log, core-run activity, and which registers the check phase reads
  always @(posedge clk1) begin
    if (rst || start) begin
      imemCount   <= 0;
      runEdges    <= 0;
      coreRunSeen <= 1'b0;
      rdAddr5Seen <= 1'b0;
    end else begin
      if (imemWe && imemCount < 128) begin
        imemAddrLog[imemCount] <= imemAddr;
        imemDataLog[imemCount] <= imemWdata;
        imemCount <= imemCount + 1;
      end
      if (coreRun) begin
        runEdges    <= runEdges + 1;
        coreRunSeen <= 1'b1;
      end
      if (coreRunSeen && !coreRun && !done && regRdAddr == 5'd5) rdAddr5Seen <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
  endtask

  task automatic writeCheck(input int idx, input logic en, input int r, input logic [31:0] v);
    chkWe = 1'b1; chkIdx = CIW'(idx); chkEn = en; chkReg = 5'(r); chkVal = v;
    @(negedge clk1);
    chkWe = 1'b0;
  endtask

  task automatic applyStimulus(input int nWords, input bit withLast, input bit randomValid,
                               output int nAccepted);
    int idx = 0;
    int guard = 0;
    logic xferNow;
    while (idx < nWords && guard < 2000) begin
      if (!ldReady) break;
      ldValid = randomValid ? 1'($urandom_range(0, 1)) : 1'b1;
      ldData  = progMem[idx];
      ldLast  = withLast && (idx == nWords - 1);
      xferNow = ldValid && ldReady;
      @(negedge clk1);
      guard++;
      if (xferNow) idx++;
    end
    ldValid = 1'b0;
    ldLast  = 1'b0;
    nAccepted = idx;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk1);
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic checkImemLog(input string tag, input int n);
    int bad = 0;
    checkOutput({tag, " write count"}, imemCount, n);
    for (int i = 0; i < n && i < 128; i++)
      if (imemAddrLog[i] !== IMEM_AW'(i) || imemDataLog[i] !== progMem[i]) bad++;
    checkOutput({tag, " write addr/data errors"}, bad, 0);
  endtask

  task automatic loadTestProgram();
    progMem[0] = 32'h480200d2;
    progMem[1] = 32'h1c410000;
    progMem[2] = 32'h00222000;
    progMem[3] = 32'h04822800;
    progMem[4] = 32'hfc000000;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ldValid = 1'b0; ldLast = 1'b0; ldData = '0;
    chkWe = 1'b0; chkIdx = '0; chkEn = 1'b0; chkReg = '0; chkVal = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 1000 + 7);
    regs[1] = 32'd40; regs[2] = 32'd210; regs[4] = 32'd250; regs[5] = 32'd40;
    loadTestProgram();
    repeat (3) @(negedge clk1);

    // Reset state
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset pass", 32'(pass), 32'd0);
    checkOutput("reset ld_ready", 32'(ldReady), 32'd0);
    checkOutput("reset core_run", 32'(coreRun), 32'd0);
    checkOutput("reset imem_we", 32'(imemWe), 32'd0);
    checkOutput("reset cycle_count", 32'(cycleCount), 32'd0);
    rst = 1'b0;
    @(negedge clk1);

    // Program that halts after 12 run cycles, all four checks match
    writeCheck(0, 1'b1, 1, 32'd40);
    writeCheck(1, 1'b1, 2, 32'd210);
    writeCheck(2, 1'b1, 4, 32'd250);
    writeCheck(3, 1'b1, 5, 32'd40);
    haltEn = 1'b1; haltAfter = 12;
    pulseStart();
    checkOutput("load ld_ready", 32'(ldReady), 32'd1);
    applyStimulus(5, 1'b1, 1'b0, accepted);
    checkOutput("t1 words accepted", accepted, 5);
    writeCheck(0, 1'b1, 1, 32'd99);
    waitDone("t1 done", 300);
    checkOutput("t1 pass", 32'(pass), 32'd1);
    checkOutput("t1 cycle_count", 32'(cycleCount), 32'd12);
    checkOutput("t1 timeout", 32'(timeout), 32'd0);
    checkOutput("t1 core_run edges", runEdges, 17);
    checkImemLog("t1 imem", 5);
    repeat (3) @(negedge clk1);
    checkOutput("t1 done held", 32'(done), 32'd1);
    checkOutput("t1 pass held", 32'(pass), 32'd1);
    checkOutput("t1 done ld_ready", 32'(ldReady), 32'd0);
    checkOutput("t1 done core_run", 32'(coreRun), 32'd0);

    // Mismatch on entry 2, random ld_valid gaps during load
    writeCheck(2, 1'b1, 4, 32'd251);
    pulseStart();
    applyStimulus(5, 1'b1, 1'b1, accepted);
    checkOutput("t2 words accepted", accepted, 5);
    waitDone("t2 done", 300);
    checkOutput("t2 pass", 32'(pass), 32'd0);
    checkOutput("t2 fail_idx", 32'(failIdx), 32'd2);
    checkOutput("t2 entry3 not read", 32'(rdAddr5Seen), 32'd0);
    checkOutput("t2 cycle_count", 32'(cycleCount), 32'd12);
    checkImemLog("t2 imem", 5);

    // Core never halts
    haltEn = 1'b0;
    pulseStart();
    applyStimulus(5, 1'b1, 1'b0, accepted);
    waitDone("t3 done", 400);
    checkOutput("t3 timeout", 32'(timeout), 32'd1);
    checkOutput("t3 pass", 32'(pass), 32'd0);
    checkOutput("t3 cycle_count", 32'(cycleCount), 32'd200);
    checkOutput("t3 core_run edges", runEdges, 200);
    checkOutput("t3 core_run", 32'(coreRun), 32'd0);

    // 65 words without ld_last overflow the 64-word IMEM
    for (int i = 0; i < 65; i++) progMem[i] = 32'h1000_0000 + 32'(i * 7);
    pulseStart();
    applyStimulus(65, 1'b0, 1'b0, accepted);
    checkOutput("t4 words accepted", accepted, 64);
    waitDone("t4 done", 20);
    checkOutput("t4 overflow", 32'(overflow), 32'd1);
    checkOutput("t4 pass", 32'(pass), 32'd0);
    checkOutput("t4 ld_ready", 32'(ldReady), 32'd0);
    checkOutput("t4 core never run", 32'(coreRunSeen), 32'd0);
    checkImemLog("t4 imem", 64);

    // start ignored mid-RUN, then reset at RUN cycle 5
    loadTestProgram();
    pulseStart();
    applyStimulus(5, 1'b1, 1'b0, accepted);
    for (int n = 0; n < 20 && !coreRun; n++) @(negedge clk1);
    checkOutput("t5 in run", 32'(coreRun), 32'd1);
    pulseStart();
    checkOutput("t5 start ignored count", 32'(cycleCount), 32'd1);
    checkOutput("t5 start ignored ld_ready", 32'(ldReady), 32'd0);
    checkOutput("t5 start ignored core_run", 32'(coreRun), 32'd1);
    repeat (3) @(negedge clk1);
    checkOutput("t5 run cycle 5 count", 32'(cycleCount), 32'd4);
    rst = 1'b1;
    @(negedge clk1);
    checkOutput("t5 rst core_run", 32'(coreRun), 32'd0);
    checkOutput("t5 rst cycle_count", 32'(cycleCount), 32'd0);
    checkOutput("t5 rst done", 32'(done), 32'd0);
    checkOutput("t5 rst timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk1);

    // Table cleared by reset: entry 2 (mismatch) no longer enabled
    haltEn = 1'b1; haltAfter = 12;
    pulseStart();
    applyStimulus(5, 1'b1, 1'b0, accepted);
    waitDone("t5b done", 300);
    checkOutput("t5b pass table cleared", 32'(pass), 32'd1);
    checkOutput("t5b fail_idx", 32'(failIdx), 32'd0);

    // Halt on the final timeout cycle: halt wins
    haltAfter = 199;
    pulseStart();
    applyStimulus(5, 1'b1, 1'b0, accepted);
    waitDone("t6 done", 400);
    checkOutput("t6 timeout", 32'(timeout), 32'd0);
    checkOutput("t6 pass", 32'(pass), 32'd1);
    checkOutput("t6 cycle_count", 32'(cycleCount), 32'd199);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
